// File: rtl/maze_bram_arbiter.sv
// Arbitrates a single-port maze BRAM between the maze generator (writes) and
// two readers (collision checker, display renderer), with a generation lock.
module maze_bram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gen_start,
  input  logic              gen_done,
  input  logic              gen_we,
  input  logic [ADDR_W-1:0] gen_addr,
  input  logic [DATA_W-1:0] gen_data,
  input  logic              col_req,
  input  logic [ADDR_W-1:0] col_addr,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              col_grant,
  output logic              disp_grant,
  output logic              col_rvalid,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] col_rdata,
  output logic [DATA_W-1:0] disp_rdata,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              locked,
  output logic              maze_valid
);

  typedef enum logic {READY, LOCKED} state_e;
  typedef enum logic {OWN_COL, OWN_DISP} owner_e;

  state_e              state_q, state_d;
  logic                maze_valid_q, maze_valid_d;
  owner_e              rr_last_q, rr_last_d;
  logic [2:1]          vld_pipe_q, vld_pipe_d;
  owner_e              own_pipe_q [2:1];
  owner_e              own_pipe_d [2:1];
  logic [DATA_W-1:0]   col_rdata_q, col_rdata_d;
  logic [DATA_W-1:0]   disp_rdata_q, disp_rdata_d;

  // Lock FSM: a start always wins over a coincident done.
  always_comb begin
    state_d      = state_q;
    maze_valid_d = maze_valid_q;
    if (gen_start) begin
      state_d      = LOCKED;
      maze_valid_d = 1'b0;
    end else if (state_q == LOCKED && gen_done) begin
      state_d      = READY;
      maze_valid_d = 1'b1;
    end
  end

  // Port mux: writes first, then round-robin readers while unlocked.
  always_comb begin
    col_grant  = 1'b0;
    disp_grant = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = '0;
    bram_din   = '0;
    rr_last_d  = rr_last_q;
    if (gen_we) begin
      bram_we   = 1'b1;
      bram_addr = gen_addr;
      bram_din  = gen_data;
    end else if (state_q == READY) begin
      if (col_req && (!disp_req || rr_last_q == OWN_DISP)) begin
        col_grant = 1'b1;
        bram_addr = col_addr;
        rr_last_d = OWN_COL;
      end else if (disp_req) begin
        disp_grant = 1'b1;
        bram_addr  = disp_addr;
        rr_last_d  = OWN_DISP;
      end
    end
  end

  // Stage 1 marks the cycle bram_dout is valid; stage 2 is the rvalid cycle.
  always_comb begin
    vld_pipe_d[1] = col_grant | disp_grant;
    own_pipe_d[1] = disp_grant ? OWN_DISP : OWN_COL;
    vld_pipe_d[2] = vld_pipe_q[1];
    own_pipe_d[2] = own_pipe_q[1];
    col_rdata_d   = col_rdata_q;
    disp_rdata_d  = disp_rdata_q;
    if (vld_pipe_q[1]) begin
      if (own_pipe_q[1] == OWN_DISP) disp_rdata_d = bram_dout;
      else                           col_rdata_d  = bram_dout;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= READY;
      maze_valid_q  <= 1'b0;
      rr_last_q     <= OWN_DISP;
      vld_pipe_q    <= '0;
      own_pipe_q[1] <= OWN_COL;
      own_pipe_q[2] <= OWN_COL;
      col_rdata_q   <= '0;
      disp_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      maze_valid_q  <= maze_valid_d;
      rr_last_q     <= rr_last_d;
      vld_pipe_q    <= vld_pipe_d;
      own_pipe_q[1] <= own_pipe_d[1];
      own_pipe_q[2] <= own_pipe_d[2];
      col_rdata_q   <= col_rdata_d;
      disp_rdata_q  <= disp_rdata_d;
    end
  end

  assign col_rvalid  = vld_pipe_q[2] && (own_pipe_q[2] == OWN_COL);
  assign disp_rvalid = vld_pipe_q[2] && (own_pipe_q[2] == OWN_DISP);
  assign col_rdata   = col_rdata_q;
  assign disp_rdata  = disp_rdata_q;
  assign locked      = (state_q == LOCKED);
  assign maze_valid  = maze_valid_q;

endmodule

// File: tb/tb_maze_bram_arbiter.sv
// Scoreboard bench for maze_bram_arbiter: random + directed stimulus against a
// behavioural model; a separate monitor checks read responses.
module tb_maze_bram_arbiter;
  localparam int AW = 8;
  localparam int DW = 9;

  logic clk = 1'b0;
  logic reset;
  logic gen_start, gen_done, gen_we;
  logic [AW-1:0] gen_addr, col_addr, disp_addr, bram_addr;
  logic [DW-1:0] gen_data, col_rdata, disp_rdata, bram_din, bram_dout;
  logic col_req, disp_req, col_grant, disp_grant, col_rvalid, disp_rvalid;
  logic bram_we, locked, maze_valid;

  always #5 clk = ~clk;

  maze_bram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .gen_start(gen_start), .gen_done(gen_done), .gen_we(gen_we),
    .gen_addr(gen_addr), .gen_data(gen_data),
    .col_req(col_req), .col_addr(col_addr),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .col_grant(col_grant), .disp_grant(disp_grant),
    .col_rvalid(col_rvalid), .disp_rvalid(disp_rvalid),
    .col_rdata(col_rdata), .disp_rdata(disp_rdata),
    .bram_addr(bram_addr), .bram_we(bram_we), .bram_din(bram_din),
    .bram_dout(bram_dout), .locked(locked), .maze_valid(maze_valid)
  );

  // Environment BRAM: one-cycle read latency.
  logic [DW-1:0] bram_mem [256];
  always @(posedge clk) begin
    if (bram_we) bram_mem[bram_addr] <= bram_din;
    bram_dout <= bram_mem[bram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model
  logic [DW-1:0] ref_mem [256];
  bit m_locked, m_mv, m_last_disp;
  typedef struct { int due; logic [DW-1:0] data; } rd_t;
  rd_t col_q[$];
  rd_t disp_q[$];
  logic [DW-1:0] exp_col_rd, exp_disp_rd;

  always @(negedge clk) begin : mon
    bit ev;
    rd_t e;
    ev = (col_q.size() > 0) && (col_q[0].due == cyc);
    chk("col_rvalid", col_rvalid, ev);
    if (ev) begin e = col_q.pop_front(); exp_col_rd = e.data; end
    chk("col_rdata", col_rdata, exp_col_rd);
    ev = (disp_q.size() > 0) && (disp_q[0].due == cyc);
    chk("disp_rvalid", disp_rvalid, ev);
    if (ev) begin e = disp_q.pop_front(); exp_disp_rd = e.data; end
    chk("disp_rdata", disp_rdata, exp_disp_rd);
  end

  task automatic drive_idle();
    gen_start = 0; gen_done = 0; gen_we = 0; gen_addr = 0; gen_data = 0;
    col_req = 0; col_addr = 0; disp_req = 0; disp_addr = 0;
  endtask

  task automatic step(input bit gs, input bit gd, input bit we, input logic [AW-1:0] ga,
                      input logic [DW-1:0] gdat, input bit cr, input logic [AW-1:0] ca,
                      input bit dr, input logic [AW-1:0] da);
    bit ecg, edg, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(posedge clk); #2;
    gen_start = gs; gen_done = gd; gen_we = we; gen_addr = ga; gen_data = gdat;
    col_req = cr; col_addr = ca; disp_req = dr; disp_addr = da;
    #2;
    ecg = 0; edg = 0; ewe = 0; ea = 0; ed = 0;
    if (we) begin
      ewe = 1; ea = ga; ed = gdat;
    end else if (!m_locked) begin
      if (cr && dr) begin
        if (m_last_disp) ecg = 1; else edg = 1;
      end else if (cr) ecg = 1;
      else if (dr) edg = 1;
      if (ecg) ea = ca;
      if (edg) ea = da;
    end
    chk("col_grant", col_grant, ecg);
    chk("disp_grant", disp_grant, edg);
    chk("bram_we", bram_we, ewe);
    chk("bram_addr", bram_addr, ea);
    chk("bram_din", bram_din, ed);
    chk("locked", locked, m_locked);
    chk("maze_valid", maze_valid, m_mv);
    if (we) ref_mem[ga] = gdat;
    if (ecg) begin col_q.push_back('{due: cyc + 2, data: ref_mem[ca]}); m_last_disp = 0; end
    if (edg) begin disp_q.push_back('{due: cyc + 2, data: ref_mem[da]}); m_last_disp = 1; end
    if (gs) begin m_locked = 1; m_mv = 0; end
    else if (m_locked && gd) begin m_locked = 0; m_mv = 1; end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #2;
    reset = 1;
    drive_idle();
    col_q.delete(); disp_q.delete();
    exp_col_rd = 0; exp_disp_rd = 0;
    m_locked = 0; m_mv = 0; m_last_disp = 1;
    #2;
    chk("rst_locked", locked, 0);
    chk("rst_maze_valid", maze_valid, 0);
    chk("rst_bram_addr", bram_addr, 0);
    repeat (n) @(posedge clk);
    #2 reset = 0;
  endtask

  task automatic rand_step(input int gs_mod);
    step(($urandom % gs_mod) == 0, ($urandom % 6) == 0, ($urandom % 4) == 0,
         AW'($urandom), DW'($urandom), $urandom % 2, AW'($urandom),
         $urandom % 2, AW'($urandom));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      bram_mem[i] = DW'(i * 37 + 5);
      ref_mem[i]  = DW'(i * 37 + 5);
    end
    bram_mem[8'h11] = 9'd1;
    ref_mem[8'h11]  = 9'd1;
    exp_col_rd = 0; exp_disp_rd = 0;
    reset = 1;
    drive_idle();
    do_reset(2);

    // single collision read of a known cell
    step(0, 0, 0, 0, 0, 1, 8'h11, 0, 0);
    idle(3);
    chk("col_rdata_0x11", col_rdata, 9'd1);

    // both readers back-to-back: alternating grants
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1, AW'($urandom), 1, AW'($urandom));
    idle(3);

    // write beats a reader, reader granted next cycle
    step(0, 0, 1, 8'h05, 9'd0, 1, 8'h05, 0, 0);
    step(0, 0, 0, 0, 0, 1, 8'h05, 0, 0);
    idle(3);

    // start and done together: start wins
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 8'h20, 1, 8'h21);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // full generation pass with readers knocking while locked
    step(1, 0, 0, 0, 0, 1, 8'h30, 1, 8'h31);
    for (int i = 0; i < 256; i++)
      step(0, 0, 1, AW'(i), DW'($urandom), $urandom % 2, AW'($urandom), $urandom % 2, AW'($urandom));
    step(0, 1, 0, 0, 0, 1, 8'h40, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 1, AW'($urandom), 1, AW'($urandom));
    idle(3);

    // reset one cycle after a display grant drops the read
    step(0, 0, 0, 0, 0, 0, 0, 1, 8'h11);
    do_reset(2);
    idle(4);

    for (int i = 0; i < 500; i++) rand_step(25);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/maze_bram_arbiter.md
MAZE_BRAM_ARBITER -- requirements
Module: maze_bram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8: maze cell address width (16x16 = 256 cells).
REQ-002 Parameter DATA_W, default 9: maze cell data width (bit 0 = wall, 1 / path, 0).
REQ-003 clk  in  1  single system clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 gen_start  in  1  one-cycle pulse: maze generation begins.
REQ-006 gen_done  in  1  level: generator finished writing.
REQ-007 gen_we  in  1  generator write request.
REQ-008 gen_addr  in  ADDR_W  generator write address.
REQ-009 gen_data  in  DATA_W  generator write data.
REQ-010 col_req / disp_req  in  1  read request from collision checker / display renderer.
REQ-011 col_addr / disp_addr  in  ADDR_W  read address from each requester.
REQ-012 col_grant / disp_grant  out  1  combinational, read accepted this cycle.
REQ-013 col_rvalid / disp_rvalid  out  1  registered one-cycle pulse, read data valid.
REQ-014 col_rdata / disp_rdata  out  DATA_W  registered read data; holds its value between pulses.
REQ-015 bram_addr  out  ADDR_W, bram_we  out  1, bram_din  out  DATA_W: single-port BRAM drive, combinational.
REQ-016 bram_dout  in  DATA_W  BRAM read data, valid one cycle after address presented.
REQ-017 locked  out  1  high while state = LOCKED.
REQ-018 maze_valid  out  1  registered, high when a complete maze is stored.

Function
REQ-019 FSM states: READY, LOCKED; READY -> LOCKED on gen_start; LOCKED -> READY on gen_done=1 with gen_start=0.
REQ-020 gen_start and gen_done in the same cycle: gen_start wins, state is LOCKED next cycle.
REQ-021 gen_done in READY: no effect.
REQ-022 maze_valid clears on gen_start and sets on the LOCKED -> READY transition.
REQ-023 Priority, every cycle: gen_we > readers; when gen_we=1, bram_we=1, bram_addr=gen_addr, bram_din=gen_data, no grant.
REQ-024 gen_we is honoured in both states.
REQ-025 In LOCKED, col_grant = disp_grant = 0 regardless of requests; requests are not queued.
REQ-026 In READY with gen_we=0: if exactly one reader requests, it is granted.
REQ-027 If both readers request, the one not granted most recently wins; rr_last pointer updates on each grant.
REQ-028 On a reader grant, bram_we=0 and bram_addr = granted reader's address.
REQ-029 Idle cycles (no grant, no write): bram_we=0, bram_addr=0, bram_din=0.
REQ-030 Read latency: grant in cycle N; bram_dout sampled in N+1 into the requester's rdata; rvalid high in N+2 only.
REQ-031 A 2-stage tag pipeline {valid, owner} tracks reads; back-to-back grants every cycle are supported (throughput 1 read/cycle).
REQ-032 Reads granted before a gen_start still complete, returning pre-write data.
REQ-033 A requester holding req high receives at most one grant per cycle; each grant yields exactly one rvalid.

Reset
REQ-034 On reset: state READY, maze_valid=0, rr_last=display (collision wins the first tie), tag pipeline cleared.
REQ-035 On reset: all rvalid=0 and all rdata=0; in-flight reads are dropped with no rvalid.
REQ-036 Combinational outputs follow REQ-023..029 from reset values immediately.

Verification
REQ-037 Reset, then col_req=1 with col_addr=0x11 (model BRAM holds 9'd1): col_grant in cycle 0, bram_addr=0x11, col_rvalid in cycle 2, col_rdata=9'd1.
REQ-038 Both readers request continuously for 6 cycles: grants alternate col, disp, col...; each rvalid trails its grant by 2 cycles.
REQ-039 gen_we=1 (addr 0x05, data 0) together with col_req: bram_we=1, col_grant=0; next cycle col is granted.
REQ-040 gen_start pulse, then 256 writes, then gen_done: locked=1 and no grants during the writes; maze_valid rises the cycle after gen_done.
REQ-041 gen_start and gen_done asserted together: state LOCKED and maze_valid=0.
REQ-042 Reset asserted one cycle after a disp grant: no disp_rvalid follows and disp_rdata=0.
